dram_controller: RTL
====================

# dram_controller

Responder side of the CPU's DRAM select/DTACK handshake. Converts a decoded 68000 bus cycle into RAS/CAS-multiplexed DRAM strobes and returns an active-low DTACK once data is valid or latched. Runs periodic CAS-before-RAS refresh, interleaved between CPU accesses. Sits between the system controller's DRAM select and acknowledge lines and the SIMM socket.

## Interface
Parameters:
- ROW_BITS, 11, DRAM multiplexed-address width
- COL_BITS, 10, column bits taken from the CPU word address
- REFRESH_DIV, 125, CPU clocks between refresh requests (15.6 µs at 8 MHz)
- PRECHARGE_CYCLES, 2, minimum RAS-high clocks after any RAS-low period

Ports:
- CLK  in  1  CPU clock; all state changes on rising edge
- RST  in  1  reset, asynchronous, active-high
- DRAM  in  1  active-low select from system controller
- AS, UDS, LDS  in  1 each  active-low 68000 strobes
- RW  in  1  1 = read, 0 = write
- ADDR  in  ROW_BITS+COL_BITS  CPU word address, A[ROW_BITS+COL_BITS:1]
- DRAM_ADDR  out  ROW_BITS  multiplexed row/column address
- RAS_N  out  1  row strobe
- CAS_U_N, CAS_L_N  out  1 each  column strobes, upper/lower byte lanes
- WE_N  out  1  DRAM write enable
- DTACK_DRAM  out  1  active-low acknowledge to system controller

## Operation
- States: IDLE, ROW, COL, ACK, PRE, REF_CAS, REF_RAS, REF_HOLD.
- IDLE: if refresh pending, go to REF_CAS. Otherwise, if ~DRAM & ~AS, go to ROW. Refresh wins a simultaneous request; the access waits with DTACK high.
- ROW: RAS_N=0. WE_N latched from RW (~RW → 0). Next state COL.
- COL: DRAM_ADDR switches to the column field. For reads, CAS is asserted at the next edge. For writes, stay in COL until UDS or LDS is low.
- Entering ACK: CAS_U_N=UDS, CAS_L_N=LDS (registered), DTACK_DRAM=0.
- ACK: hold while AS is low. AS high → PRE.
- AS going high in ROW or COL (aborted cycle) → PRE, with no CAS and no DTACK.
- PRE: RAS/CAS/WE/DTACK all inactive for PRECHARGE_CYCLES clocks, then IDLE.
- Refresh: REF_CAS drives both CAS low. REF_RAS drives RAS low. REF_HOLD holds for 1 clock. Then PRE. WE_N=1 throughout.
- Refresh timer: free-running counter 0..REFRESH_DIV-1. Wrap sets a sticky pending flag, cleared on entry to REF_CAS. Further wraps while pending are absorbed.
- DRAM_ADDR = ADDR[COL_BITS+ROW_BITS:COL_BITS+1] (row) outside COL/ACK, and zero-extended ADDR[COL_BITS:1] (column) in COL/ACK.

## Timing
- Reset value (immediate, asynchronous): state IDLE, RAS_N=CAS_U_N=CAS_L_N=WE_N=DTACK_DRAM=1, refresh counter 0, pending 0.
- Reset asserted mid-access or mid-refresh forces all strobes high at once; no partial cycle completes.
- Read latency: request sampled at edge 0 → RAS low at edge 1 → column address at edge 2 → CAS and DTACK low at edge 3.
- Write latency: DTACK at the first edge after the data strobe is seen low in COL, 3 edges minimum.
- DTACK deasserts on the first edge with AS high. It is never low outside ACK.
- Worst-case access latency: 4 + PRECHARGE_CYCLES clocks added when a refresh is pending.
- All control outputs are registered. DRAM_ADDR is combinational from state and ADDR.

## Structure
- Shared package dram_pkg holds:
  - state enum
  - default timing constants: REFRESH_DIV, PRECHARGE_CYCLES
- Sub-module dram_refresh_timer: counter plus sticky pending flag, with a clear input.

## Test plan
- Reset: pulse RST during ACK of a read → all strobes 1 within the same cycle, state IDLE, no DTACK.
- Read: ADDR=0x12345, UDS=LDS=0, RW=1 → RAS_N low at edge 1, DRAM_ADDR=row then column 0x345, both CAS and DTACK low at edge 3, release 1 edge after AS high, then 2 PRE clocks.
- Byte write: RW=0, LDS asserted 2 clocks after AS → WE_N=0 from ROW, CAS_L_N only, DTACK 1 edge after LDS low.
- Refresh: idle bus → CAS_U_N/CAS_L_N low one edge before RAS_N, every 125 clocks, WE_N=1.
- Collision: request in the same cycle the refresh flag is set → full refresh plus precharge first, then access, DTACK never low during refresh.
- Abort: AS rises in ROW → no CAS, no DTACK, PRE entered, next request served normally.

Source files
------------

// File: rtl/dram_pkg.sv
// Shared types and default timing for the DRAM controller slice.
package dram_pkg;

  // CPU clocks between refresh requests (15.6 us at 8 MHz).
  localparam int REFRESH_DIV_DEFAULT      = 125;
  // Minimum RAS-high clocks after any RAS-low period.
  localparam int PRECHARGE_CYCLES_DEFAULT = 2;

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    COL,
    ACK,
    PRE,
    REF_CAS,
    REF_RAS,
    REF_HOLD
  } state_e;

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh divider with a sticky request flag.
module dram_refresh_timer
  import dram_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  output logic pending
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(REFRESH_DIV - 1));

  // Count 0..REFRESH_DIV-1; a wrap raises pending, which stays up until the
  // controller takes the refresh (extra wraps meanwhile are simply absorbed).
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (clear) begin
        pending <= 1'b0;
      end else if (wrap) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_controller.sv
// 68000 DRAM responder: RAS/CAS address multiplexing, DTACK generation and
// CAS-before-RAS refresh interleaved between CPU accesses.
module dram_controller
  import dram_pkg::*;
#(
  parameter int ROW_BITS         = 11,
  parameter int COL_BITS         = 10,
  parameter int REFRESH_DIV      = REFRESH_DIV_DEFAULT,
  parameter int PRECHARGE_CYCLES = PRECHARGE_CYCLES_DEFAULT
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         DRAM,
  input  logic                         AS,
  input  logic                         UDS,
  input  logic                         LDS,
  input  logic                         RW,
  input  logic [ROW_BITS+COL_BITS-1:0] ADDR,
  output logic [ROW_BITS-1:0]          DRAM_ADDR,
  output logic                         RAS_N,
  output logic                         CAS_U_N,
  output logic                         CAS_L_N,
  output logic                         WE_N,
  output logic                         DTACK_DRAM
);

  localparam int PW = (PRECHARGE_CYCLES > 1) ? $clog2(PRECHARGE_CYCLES) : 1;

  state_e        state, state_d;
  logic [PW-1:0] pre_cnt, pre_cnt_d;
  logic          req_q;
  logic          ref_pending, ref_clear;
  logic          ras_d, cas_u_d, cas_l_d, we_d, dtack_d;

  dram_refresh_timer #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (ref_clear),
    .pending(ref_pending)
  );

  // Next state plus the values every strobe takes on entering that state.
  // NOTE: every signal gets a default first so no path leaves one unassigned.
  always_comb begin
    state_d   = state;
    pre_cnt_d = '0;
    ref_clear = 1'b0;
    ras_d     = 1'b1;
    cas_u_d   = 1'b1;
    cas_l_d   = 1'b1;
    we_d      = 1'b1;
    dtack_d   = 1'b1;
    case (state)
      IDLE: begin
        // Refresh wins over a simultaneous CPU request.
        if (ref_pending) begin
          state_d   = REF_CAS;
          ref_clear = 1'b1;
          cas_u_d   = 1'b0;
          cas_l_d   = 1'b0;
        end else if (req_q) begin
          state_d = ROW;
          ras_d   = 1'b0;
          we_d    = RW;
        end
      end
      ROW: begin
        if (AS) begin
          state_d = PRE;
        end else begin
          state_d = COL;
          ras_d   = 1'b0;
          we_d    = WE_N;
        end
      end
      COL: begin
        if (AS) begin
          state_d = PRE;
        end else begin
          ras_d = 1'b0;
          we_d  = WE_N;
          // Reads strobe CAS straight away; writes wait for a data strobe.
          if (WE_N || !UDS || !LDS) begin
            state_d = ACK;
            cas_u_d = UDS;
            cas_l_d = LDS;
            dtack_d = 1'b0;
          end
        end
      end
      ACK: begin
        if (AS) begin
          state_d = PRE;
        end else begin
          ras_d   = 1'b0;
          we_d    = WE_N;
          cas_u_d = CAS_U_N;
          cas_l_d = CAS_L_N;
          dtack_d = 1'b0;
        end
      end
      PRE: begin
        if (pre_cnt == PW'(PRECHARGE_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          pre_cnt_d = pre_cnt + PW'(1);
        end
      end
      REF_CAS: begin
        state_d = REF_RAS;
        ras_d   = 1'b0;
        cas_u_d = 1'b0;
        cas_l_d = 1'b0;
      end
      REF_RAS: begin
        state_d = REF_HOLD;
        ras_d   = 1'b0;
        cas_u_d = 1'b0;
        cas_l_d = 1'b0;
      end
      REF_HOLD: begin
        state_d = PRE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, precharge count, request sample and registered strobes; reset
  // drops every strobe immediately so no partial cycle completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      pre_cnt    <= '0;
      req_q      <= 1'b0;
      RAS_N      <= 1'b1;
      CAS_U_N    <= 1'b1;
      CAS_L_N    <= 1'b1;
      WE_N       <= 1'b1;
      DTACK_DRAM <= 1'b1;
    end else begin
      state      <= state_d;
      pre_cnt    <= pre_cnt_d;
      req_q      <= ~DRAM & ~AS;
      RAS_N      <= ras_d;
      CAS_U_N    <= cas_u_d;
      CAS_L_N    <= cas_l_d;
      WE_N       <= we_d;
      DTACK_DRAM <= dtack_d;
    end
  end

  // Column field while CAS may be active, row field everywhere else.
  always_comb begin
    if (state == COL || state == ACK) begin
      DRAM_ADDR = ROW_BITS'(ADDR[COL_BITS-1:0]);
    end else begin
      DRAM_ADDR = ADDR[ROW_BITS+COL_BITS-1:COL_BITS];
    end
  end

endmodule
